// File: rtl/rv_fanout_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// rv_fanout_pipe_reg_if
//   Handshake bundle for the fanout pipeline register: upstream data/valid/ready
//   and the downstream track (data/valid out, merged ready in).
//
//   Signals (named from the pipeline register's point of view):
//     data_in   [DATA_WIDTH] upstream data
//     valid_in                upstream valid
//     ready_out               ready back to upstream
//     data_out  [DATA_WIDTH] data onto the fanout track
//     valid_out               valid to the fanout sinks
//     ready_in                merged ready from the fanout ready-merge stage
//
//   Modports:
//     slave  - the pipeline register itself
//     master - the environment around it (upstream source + fanout stage)
// -----------------------------------------------------------------------------
interface rv_fanout_pipe_reg_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  ready_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  ready_in;

   modport slave (
      input  data_in, valid_in, ready_in,
      output ready_out, data_out, valid_out
   );

   modport master (
      output data_in, valid_in, ready_in,
      input  ready_out, data_out, valid_out
   );
endinterface

// File: rtl/rv_fanout_pipe_reg.sv
// -----------------------------------------------------------------------------
// rv_fanout_pipe_reg
//   Ready/valid pipeline register feeding the fanout ready-merge stage of the
//   CGRA interconnect. In registered mode it is a 2-entry FIFO, so ready_out is
//   a pure function of stored state and the ready path is cut at every hop.
//   In pass-through mode data/valid/ready flow straight through.
//
//   Ports:
//     clk        single clock
//     rst_n      asynchronous active-low reset
//     cfg_reg_en 1 = registered (FIFO) mode, 0 = combinational pass-through
//     flush      synchronous clear of FIFO contents (and stall counter)
//     bus        handshake bundle (slave modport), see rv_fanout_pipe_reg_if
//     stall_cnt  cycles with valid_out=1 and ready_in=0, saturating
//
//   Optional feature macro: RV_FANOUT_PIPE_STALL_CNT_EN
//     defined   - stall counter is built
//     undefined - stall_cnt is tied to 0, no counter flops
// -----------------------------------------------------------------------------
module rv_fanout_pipe_reg #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_reg_en,
   input  logic                 flush,
   rv_fanout_pipe_reg_if.slave  bus,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   logic [DATA_WIDTH-1:0] r_mem [0:1];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;

   logic                  w_fifo_ready;
   logic                  w_fifo_valid;
   logic [DATA_WIDTH-1:0] w_fifo_data;
   logic                  w_push;
   logic                  w_pop;

   // FIFO-side handshake depends only on stored state: no path from ready_in.
   assign w_fifo_ready = (r_count != 2'd2);
   assign w_fifo_valid = (r_count != 2'd0);
   assign w_fifo_data  = w_fifo_valid ? r_mem[r_rd_ptr] : '0;

   // A push during flush is dropped; nothing moves through the FIFO in
   // pass-through mode.
   assign w_push = cfg_reg_en & ~flush & bus.valid_in & w_fifo_ready;
   assign w_pop  = cfg_reg_en & w_fifo_valid & bus.ready_in;

   assign bus.ready_out = cfg_reg_en ? w_fifo_ready : bus.ready_in;
   assign bus.valid_out = cfg_reg_en ? w_fifo_valid : bus.valid_in;
   assign bus.data_out  = cfg_reg_en ? w_fifo_data  : bus.data_in;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else if (!cfg_reg_en || flush) begin
         // Pass-through holds the FIFO empty, so a later switch to registered
         // mode starts clean.
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; its contents are never visible while
   // r_count==0 because data_out is forced to 0 then.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.data_in;
   end

`ifdef RV_FANOUT_PIPE_STALL_CNT_EN
   logic                 w_stall;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   // Counts on the muxed outputs so both modes are covered.
   assign w_stall = bus.valid_out & ~bus.ready_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (flush) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_fanout_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_rv_fanout_pipe_reg
//   Self-checking bench for rv_fanout_pipe_reg. Reference model is a queue of
//   accepted words (depth 2) plus a saturating stall counter.
// -----------------------------------------------------------------------------
module tb_rv_fanout_pipe_reg;

   localparam int DW = 16;
   localparam int CW = 16;

   logic          clk;
   logic          rst_n;
   logic          cfg_reg_en;
   logic          flush;
   logic [CW-1:0] stall_cnt;

   rv_fanout_pipe_reg_if #(.DATA_WIDTH(DW)) bus ();

   rv_fanout_pipe_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_reg_en (cfg_reg_en),
      .flush      (flush),
      .bus        (bus.slave),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- reference model ----------------
   logic [DW-1:0] q[$];
   int unsigned   exp_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_valid();
      if (!cfg_reg_en) return bus.valid_in;
      return q.size() != 0;
   endfunction

   function automatic logic m_ready();
      if (!cfg_reg_en) return bus.ready_in;
      return q.size() < 2;
   endfunction

   function automatic logic [DW-1:0] m_data();
      if (!cfg_reg_en) return bus.data_in;
      return (q.size() != 0) ? q[0] : '0;
   endfunction

   function automatic int unsigned m_stall();
`ifdef RV_FANOUT_PIPE_STALL_CNT_EN
      return exp_stall;
`else
      return 0;
`endif
   endfunction

   // Advance model by one clock edge using the inputs currently applied.
   task automatic model_step();
      logic push, pop, stall;
      stall = m_valid() & ~bus.ready_in;
      push  = cfg_reg_en & ~flush & bus.valid_in & (q.size() < 2);
      pop   = cfg_reg_en & (q.size() != 0) & bus.ready_in;
      if (flush || !cfg_reg_en) begin
         q.delete();
      end else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(bus.data_in);
      end
      if (flush) exp_stall = 0;
      else if (stall && exp_stall != 32'hFFFF) exp_stall++;
   endtask

   task automatic model_reset();
      q.delete();
      exp_stall = 0;
   endtask

   // Drive inputs just after the falling edge; outputs settle by #1.
   task automatic apply(input logic cfg, input logic fl, input logic v,
                        input logic r, input logic [DW-1:0] d);
      cfg_reg_en   = cfg;
      flush        = fl;
      bus.valid_in = v;
      bus.ready_in = r;
      bus.data_in  = d;
      #1;
   endtask

   task automatic check_vs_model(input string tag);
      check({tag, ".valid"}, 32'(bus.valid_out), 32'(m_valid()));
      check({tag, ".ready"}, 32'(bus.ready_out), 32'(m_ready()));
      check({tag, ".data"},  32'(bus.data_out),  32'(m_data()));
      check({tag, ".stall"}, 32'(stall_cnt),     m_stall());
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic          cfg;
      logic          fl;
      logic          v;
      logic          r;
      logic [DW-1:0] d;
      logic          e_valid;
      logic          e_ready;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic cfg, logic fl, logic v, logic r, logic [DW-1:0] d,
                               logic ev, logic er, logic [DW-1:0] ed);
      vec_t t;
      t.cfg = cfg; t.fl = fl; t.v = v; t.r = r; t.d = d;
      t.e_valid = ev; t.e_ready = er; t.e_data = ed;
      return t;
   endfunction

   initial begin
      // streaming 1,2,3 with ready_in=1
      tbl.push_back(mk(1,0,1,1,16'h0001, 0,1,16'h0000));
      tbl.push_back(mk(1,0,1,1,16'h0002, 1,1,16'h0001));
      tbl.push_back(mk(1,0,1,1,16'h0003, 1,1,16'h0002));
      tbl.push_back(mk(1,0,0,1,16'h0000, 1,1,16'h0003));
      tbl.push_back(mk(1,0,0,1,16'h0000, 0,1,16'h0000));
      // fill to full with backpressure, CCCC held upstream, then drain
      tbl.push_back(mk(1,0,1,0,16'hAAAA, 0,1,16'h0000));
      tbl.push_back(mk(1,0,1,0,16'hBBBB, 1,1,16'hAAAA));
      tbl.push_back(mk(1,0,1,0,16'hCCCC, 1,0,16'hAAAA));
      tbl.push_back(mk(1,0,1,1,16'hCCCC, 1,0,16'hAAAA));
      tbl.push_back(mk(1,0,1,1,16'hCCCC, 1,1,16'hBBBB));
      tbl.push_back(mk(1,0,0,1,16'h0000, 1,1,16'hCCCC));
      tbl.push_back(mk(1,0,0,1,16'h0000, 0,1,16'h0000));
      // two stored, flush with a push of 5555 that must be dropped
      tbl.push_back(mk(1,0,1,0,16'h1111, 0,1,16'h0000));
      tbl.push_back(mk(1,0,1,0,16'h2222, 1,1,16'h1111));
      tbl.push_back(mk(1,1,1,0,16'h5555, 1,0,16'h1111));
      tbl.push_back(mk(1,0,0,0,16'h0000, 0,1,16'h0000));
      tbl.push_back(mk(1,0,0,1,16'h0000, 0,1,16'h0000));
      // pass-through, then back to registered starting empty
      tbl.push_back(mk(0,0,1,0,16'h1234, 1,0,16'h1234));
      tbl.push_back(mk(0,0,0,1,16'hABCD, 0,1,16'hABCD));
      tbl.push_back(mk(1,0,0,1,16'h0000, 0,1,16'h0000));
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      model_reset();
      apply(1, 0, 0, 0, '0);
      check("reset.valid", 32'(bus.valid_out), 32'd0);
      check("reset.ready", 32'(bus.ready_out), 32'd1);
      check("reset.data",  32'(bus.data_out),  32'd0);
      check("reset.stall", 32'(stall_cnt),     32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: hand-derived expectations, with the model kept in step.
      foreach (tbl[i]) begin
         apply(tbl[i].cfg, tbl[i].fl, tbl[i].v, tbl[i].r, tbl[i].d);
         check($sformatf("tbl%0d.valid", i), 32'(bus.valid_out), 32'(tbl[i].e_valid));
         check($sformatf("tbl%0d.ready", i), 32'(bus.ready_out), 32'(tbl[i].e_ready));
         check($sformatf("tbl%0d.data",  i), 32'(bus.data_out),  32'(tbl[i].e_data));
         check($sformatf("tbl%0d.stall", i), 32'(stall_cnt),     m_stall());
         tick();
      end

      // Count held at 1 with push+pop every cycle; pointers wrap repeatedly.
      apply(1, 0, 1, 1, 16'h0010);
      tick();
      for (int i = 0; i < 10; i++) begin
         apply(1, 0, 1, 1, 16'(16'h0011 + i));
         check($sformatf("pp%0d.valid", i), 32'(bus.valid_out), 32'd1);
         check($sformatf("pp%0d.ready", i), 32'(bus.ready_out), 32'd1);
         check($sformatf("pp%0d.data",  i), 32'(bus.data_out),  32'(16'h0010 + i));
         tick();
      end
      apply(1, 0, 0, 1, '0);
      check("pp.drain", 32'(bus.data_out), 32'h001A);
      tick();
      apply(1, 0, 0, 1, '0);
      check("pp.empty", 32'(bus.valid_out), 32'd0);

      // Randomized run against the model.
      begin
         logic cfg;
         cfg = 1'b1;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) cfg = ~cfg;
            apply(cfg, ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 16'($urandom));
            check_vs_model($sformatf("rnd%0d", i));
            tick();
         end
      end

      // Reset mid-transfer: stored words vanish immediately.
      apply(1, 0, 1, 0, 16'h7777);
      tick();
      apply(1, 0, 1, 0, 16'h8888);
      tick();
      apply(1, 0, 0, 0, '0);
      check("pre_rst.ready", 32'(bus.ready_out), 32'd0);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check("rst.valid", 32'(bus.valid_out), 32'd0);
      check("rst.ready", 32'(bus.ready_out), 32'd1);
      check("rst.data",  32'(bus.data_out),  32'd0);
      check("rst.stall", 32'(stall_cnt),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(1, 0, 0, 1, '0);
      check_vs_model("post_rst");
      tick();

`ifdef RV_FANOUT_PIPE_STALL_CNT_EN
      // Stall counter saturation, then asynchronous reset mid-cycle.
      apply(1, 0, 1, 0, 16'h4242);
      tick();
      apply(1, 0, 0, 0, '0);
      for (int i = 0; i < 70000; i++) tick();
      check("sat.stall", 32'(stall_cnt), 32'hFFFF);
      check("sat.valid", 32'(bus.valid_out), 32'd1);
      check("sat.data",  32'(bus.data_out),  32'h4242);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("sat_rst.stall", 32'(stall_cnt), 32'd0);
      check("sat_rst.valid", 32'(bus.valid_out), 32'd0);
      check("sat_rst.ready", 32'(bus.ready_out), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time exceeded, %0d tests run", tests_run);
      $fatal(1);
   end

endmodule

// File: doc/rv_fanout_pipe_reg.md
Name: rv_fanout_pipe_reg

Overview:
- Ready/valid pipeline register that sits directly upstream of the fanout ready-merge stage in the CGRA interconnect.
- Drives data/valid onto a track that fans out to up to six sinks.
- Consumes the single merged ready produced by the fanout stage as its downstream ready.
- Implemented as a 2-entry FIFO so the upstream ready is fully registered, breaking the combinational ready path across switchbox hops; a config bit selects registered or pass-through mode.

Parameters:
- DATA_WIDTH, 16, width of the data word carried on the track.
- CNT_WIDTH, 16, width of the optional stall counter.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- cfg_reg_en  input  1  1 = registered (FIFO) mode; 0 = combinational pass-through.
- flush  input  1  synchronous clear of FIFO contents.
- data_in  input  DATA_WIDTH  upstream data.
- valid_in  input  1  upstream valid.
- ready_out  output  1  ready to upstream.
- data_out  output  DATA_WIDTH  data to fanout.
- valid_out  output  1  valid to fanout sinks.
- ready_in  input  1  merged ready from fanout ready-merge stage.
- stall_cnt  output  CNT_WIDTH  stall cycle count (optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, wr_ptr=0, rd_ptr=0, storage don't-care, stall_cnt=0.
  - Registered-mode outputs under reset: valid_out=0, ready_out=1, data_out=0.
- Registered mode (cfg_reg_en=1):
  - Storage: mem[0:1], 1-bit rd_ptr/wr_ptr, count in 0..2.
  - ready_out = (count != 2). Depends only on state; no combinational path from ready_in.
  - valid_out = (count != 0); data_out = mem[rd_ptr], or 0 when count==0.
  - push = valid_in & ready_out: mem[wr_ptr] <= data_in, wr_ptr toggles.
  - pop = valid_out & ready_in: rd_ptr toggles.
  - count next = count + push - pop.
  - Latency: a word accepted in cycle N appears on data_out in cycle N+1. No empty bypass.
  - Empty (count=0): a pop cannot occur. A push gives count=1 next cycle.
  - Full (count=2): ready_out=0, so no push. A pop gives count=1, and ready_out=1 in the following cycle.
  - count=1 with push and pop in the same cycle: count stays 1, both pointers toggle, order preserved.
  - Pointer wrap: 1-bit pointers wrap naturally; FIFO order must hold across unlimited wraps.
  - valid_out held with ready_in=0: data_out and valid_out stay stable until the pop.
- flush=1 (synchronous, registered mode): count, wr_ptr and rd_ptr cleared next edge.
  - Any push that cycle is discarded.
  - ready_out during the flush cycle follows the current count.
- Pass-through mode (cfg_reg_en=0):
  - data_out = data_in, valid_out = valid_in, ready_out = ready_in, all combinational.
  - FIFO state cleared every cycle (count, pointers held at 0).
  - Switching 0->1 therefore starts empty.
  - Switching 1->0 discards stored words. Config changes are legal only while the track is quiesced.
- Reset mid-transfer: all stored words are lost. No partial outputs may be visible after rst_n deasserts.

Optional Feature:
- Macro: RV_FANOUT_PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each cycle with valid_out=1 and ready_in=0 (either mode).
  - Saturates at all-ones.
  - Cleared by reset or flush.
- Undefined: stall_cnt tied to 0 and no counter flops are instantiated. The port is still present.

Test Plan:
- Reset then cfg_reg_en=1, valid_in=1 with data 0x0001,0x0002,0x0003 on consecutive cycles, ready_in=1 -> data_out 0x0001,0x0002,0x0003 on cycles 1,2,3 after acceptance, with valid_out continuous and ready_out never 0.
- ready_in=0, push 0xAAAA,0xBBBB -> ready_out=0 after second push, with 0xCCCC held upstream. Then raise ready_in -> outputs 0xAAAA,0xBBBB,0xCCCC in order, no loss or duplication.
- count=1 with simultaneous push and pop for 10 cycles on an incrementing pattern from 0x0010 -> count stays 1, data_out is 0x0010..0x0019 in order, and pointers wrap correctly.
- Two words stored, assert flush for 1 cycle with valid_in=1 data 0x5555 -> next cycle valid_out=0, ready_out=1, and 0x5555 never appears.
- cfg_reg_en=0: toggle valid_in/ready_in/data_in randomly -> outputs equal inputs in the same cycle, and stall_cnt counts only valid_in & ~ready_in cycles when the macro is defined.
- With the macro defined, hold valid_out=1 and ready_in=0 for 70000 cycles at CNT_WIDTH=16 -> stall_cnt=0xFFFF. Then assert rst_n=0 asynchronously mid-cycle -> stall_cnt=0, valid_out=0 and ready_out=1 immediately.
